// File: rtl/per2apb_bridge.sv
// per2apb_bridge: peripheral-interconnect slave to APB3 master bridge.
// One outstanding transfer; each request runs as an APB SETUP/ACCESS pair and
// returns a single-cycle r_valid response with read data, error flag and ID.
// Optional feature macro: PER2APB_TIMEOUT_EN (bounds the ACCESS phase to
// TIMEOUT_CYCLES cycles and answers with an error response on expiry).
module per2apb_bridge #(
   parameter int PER_ADDR_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int ID_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      per_slave_req_i,
   output logic                      per_slave_gnt_o,
   input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
   input  logic                      per_slave_we_i,
   input  logic [31:0]               per_slave_wdata_i,
   input  logic [3:0]                per_slave_be_i,
   input  logic [ID_WIDTH-1:0]       per_slave_id_i,
   output logic                      per_slave_r_valid_o,
   output logic                      per_slave_r_opc_o,
   output logic [31:0]               per_slave_r_rdata_o,
   output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [31:0]               pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [31:0]               prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] id_reg;
   logic                timeout;

   // Byte enables are not forwarded (APB3 full-word writes) and the upper
   // address bits are discarded; fold them into a sink so they read as intended.
   logic unused_inputs;
   assign unused_inputs = ^{per_slave_be_i, per_slave_add_i};

   // Grant only while idle; the request itself is the grant qualifier.
   assign per_slave_gnt_o = per_slave_req_i & (state == IDLE);

`ifdef PER2APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt;

   // timeout fires in the last allowed ACCESS cycle; pready in that cycle wins
   assign timeout = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count ACCESS cycles; cleared while in SETUP so each transfer starts fresh.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt <= '0;
      end else if (state == SETUP) begin
         to_cnt <= '0;
      end else if (state == ACCESS) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign timeout    = 1'b0;
   assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // Transfer FSM with all APB and response outputs registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state               <= IDLE;
         id_reg              <= '0;
         paddr_o             <= '0;
         pwdata_o            <= '0;
         pwrite_o            <= 1'b0;
         psel_o              <= 1'b0;
         penable_o           <= 1'b0;
         per_slave_r_valid_o <= 1'b0;
         per_slave_r_opc_o   <= 1'b0;
         per_slave_r_rdata_o <= '0;
         per_slave_r_id_o    <= '0;
      end else begin
         per_slave_r_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (per_slave_req_i) begin
                  paddr_o   <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
                  pwdata_o  <= per_slave_wdata_i;
                  pwrite_o  <= per_slave_we_i;
                  id_reg    <= per_slave_id_i;
                  psel_o    <= 1'b1;
                  penable_o <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (pready_i) begin
                  psel_o              <= 1'b0;
                  penable_o           <= 1'b0;
                  per_slave_r_valid_o <= 1'b1;
                  per_slave_r_opc_o   <= pslverr_i;
                  per_slave_r_rdata_o <= pwrite_o ? 32'h0 : prdata_i;
                  per_slave_r_id_o    <= id_reg;
                  state               <= IDLE;
               end else if (timeout) begin
                  psel_o              <= 1'b0;
                  penable_o           <= 1'b0;
                  per_slave_r_valid_o <= 1'b1;
                  per_slave_r_opc_o   <= 1'b1;
                  per_slave_r_rdata_o <= 32'hBADC_AB1E;
                  per_slave_r_id_o    <= id_reg;
                  state               <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
